// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: IF stage with loadable instruction memory, PC and IF/ID register
// Ports:
//   clk, Reset          - clock; synchronous active-high reset
//   LoadInstructions    - 1 = stream Instruction into sequential words, 0 = run
//   Instruction         - word written in load mode
//   Stall, BranchTaken  - hold PC and IF/ID; redirect fetch to BranchTarget
//   BranchTarget        - byte address of branch target (low two bits dropped)
//   PC                  - current fetch byte address
//   IF_ID_Instr/PCPlus4/Valid - IF/ID pipeline register
//   LoadCount           - words in the current program (kept across Reset)
//   MemFull             - load pointer has reached DEPTH
module instr_fetch_stage #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              LoadInstructions,
    input  logic [31:0]       Instruction,
    input  logic              Stall,
    input  logic              BranchTaken,
    input  logic [31:0]       BranchTarget,
    output logic [31:0]       PC,
    output logic [31:0]       IF_ID_Instr,
    output logic [31:0]       IF_ID_PCPlus4,
    output logic              IF_ID_Valid,
    output logic [ADDR_W:0]   LoadCount,
    output logic              MemFull
);
    logic [31:0]     r_mem [DEPTH];
    logic [ADDR_W:0] r_ptr;
    // Program length survives Reset, so it starts from a power-up value instead.
    logic [ADDR_W:0] r_load_count = '0;
    logic [31:0]     r_pc;
    logic [31:0]     r_instr;
    logic [31:0]     r_pc4;
    logic            r_valid;
    logic            w_full;
    logic            w_wr;
    logic [29:0]     w_idx;
    logic            w_hit;
    logic [31:0]     w_word;

    assign w_full = r_ptr == (ADDR_W+1)'(DEPTH);
    assign w_wr   = !Reset && LoadInstructions && !w_full;
    assign w_idx  = r_pc[31:2];
    // Full-width compare: indices beyond the array never alias onto low words.
    assign w_hit  = w_idx < 30'(r_load_count);
    assign w_word = w_hit ? r_mem[w_idx[ADDR_W-1:0]] : 32'h0;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_ptr[ADDR_W-1:0]] <= Instruction;
            r_load_count             <= r_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_ptr   <= '0;
            r_pc    <= '0;
            r_instr <= '0;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (LoadInstructions) begin
            if (!w_full)
                r_ptr <= r_ptr + 1'b1;
            r_pc    <= '0;
            r_instr <= '0;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (BranchTaken) begin
            r_pc    <= {BranchTarget[31:2], 2'b00};
            r_instr <= '0;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (!Stall) begin
            r_pc    <= r_pc + 32'd4;
            r_instr <= w_word;
            r_pc4   <= r_pc + 32'd4;
            r_valid <= w_hit;
        end
    end

    assign PC            = r_pc;
    assign IF_ID_Instr   = r_instr;
    assign IF_ID_PCPlus4 = r_pc4;
    assign IF_ID_Valid   = r_valid;
    assign LoadCount     = r_load_count;
    assign MemFull       = w_full;
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed plus random check of instr_fetch_stage against a program-level model
module tb_instr_fetch_stage;
    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        LoadInstructions = 1'b0;
    logic [31:0] Instruction = '0;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic [31:0] PC;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic [6:0]  LoadCount;
    logic        MemFull;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: the program is an array of words plus its length; fetch state is PC and IF/ID.
    logic [31:0] m_prog [64];
    int          m_ptr = 0;
    int          m_len = 0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_ins = '0;
    logic [31:0] m_p4 = '0;
    logic        m_v = 1'b0;

    logic [31:0] prog5 [5] = '{32'h200101A7, 32'h2002005C, 32'h2003000D, 32'h20040092, 32'h20050005};
    logic [31:0] full_words [65];

    instr_fetch_stage dut (
        .clk(clk), .Reset(Reset), .LoadInstructions(LoadInstructions),
        .Instruction(Instruction), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .PC(PC), .IF_ID_Instr(IF_ID_Instr),
        .IF_ID_PCPlus4(IF_ID_PCPlus4), .IF_ID_Valid(IF_ID_Valid),
        .LoadCount(LoadCount), .MemFull(MemFull)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic ld, input logic [31:0] ins,
                              input logic st, input logic br, input logic [31:0] tgt);
        logic [31:0] word_no;
        if (rst) begin
            m_ptr = 0; m_pc = 0; m_ins = 0; m_p4 = 0; m_v = 0;
        end else if (ld) begin
            if (m_ptr < 64) begin
                m_prog[m_ptr] = ins;
                m_ptr++;
                m_len = m_ptr;
            end
            m_pc = 0; m_ins = 0; m_p4 = 0; m_v = 0;
        end else if (br) begin
            m_pc = tgt - (tgt % 4);
            m_ins = 0; m_p4 = 0; m_v = 0;
        end else if (!st) begin
            word_no = m_pc / 4;
            m_v   = word_no < 32'(m_len);
            m_ins = m_v ? m_prog[word_no % 64] : 32'h0;
            m_p4  = m_pc + 4;
            m_pc  = m_pc + 4;
        end
    endtask

    task automatic cyc(input logic rst, input logic ld, input logic [31:0] ins,
                       input logic st, input logic br, input logic [31:0] tgt);
        @(negedge clk);
        Reset = rst; LoadInstructions = ld; Instruction = ins;
        Stall = st; BranchTaken = br; BranchTarget = tgt;
        model_step(rst, ld, ins, st, br, tgt);
        @(posedge clk);
        #1;
        chk("pc", PC, m_pc);
        chk("if_id_instr", IF_ID_Instr, m_ins);
        chk("if_id_pcplus4", IF_ID_PCPlus4, m_p4);
        chk("if_id_valid", 32'(IF_ID_Valid), 32'(m_v));
        chk("load_count", 32'(LoadCount), 32'(m_len));
        chk("mem_full", 32'(MemFull), 32'(m_ptr == 64));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0);
        chk("reset_load_count", 32'(LoadCount), 32'd0);
        for (int i = 0; i < 5; i++) cyc(0, 1, prog5[i], 0, 0, 0);
        chk("len5", 32'(LoadCount), 32'd5);
        cyc(1, 0, 0, 0, 0, 0);
        run(1);
        chk("first_word", IF_ID_Instr, 32'h200101A7);
        chk("first_pc4", IF_ID_PCPlus4, 32'd4);
        run(1);
        chk("pc_at_8", PC, 32'd8);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("stall_instr", IF_ID_Instr, 32'h2002005C);
        chk("stall_pc", PC, 32'd8);
        run(1);
        chk("resume_instr", IF_ID_Instr, 32'h2003000D);
        run(1);
        chk("pc_at_16", PC, 32'd16);
        cyc(0, 0, 0, 1, 1, 32'd4);
        chk("branch_pc", PC, 32'd4);
        chk("branch_squash", 32'(IF_ID_Valid), 32'd0);
        run(1);
        chk("branch_target_word", IF_ID_Instr, 32'h2002005C);
        cyc(0, 0, 0, 0, 1, 32'h00000101);
        chk("misaligned_pc", PC, 32'h00000100);
        run(1);
        chk("no_alias_instr", IF_ID_Instr, 32'h0);
        chk("no_alias_valid", 32'(IF_ID_Valid), 32'd0);
        cyc(0, 0, 0, 0, 1, 32'd0);
        run(3);
        chk("pc_at_12", PC, 32'd12);
        cyc(1, 0, 0, 0, 0, 0);
        chk("midrun_reset_pc", PC, 32'd0);
        run(1);
        chk("rerun_word0", IF_ID_Instr, 32'h200101A7);
        run(8);
        chk("past_end_valid", 32'(IF_ID_Valid), 32'd0);
        cyc(0, 0, 0, 0, 1, 32'hFFFFFFFE);
        run(1);
        chk("wrap_pc", PC, 32'd0);
        run(1);
        chk("wrap_word0", IF_ID_Instr, 32'h200101A7);
        cyc(0, 1, 32'hABCD0001, 0, 0, 0);
        chk("midrun_load_pc", PC, 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65; i++) full_words[i] = $urandom;
        for (int i = 0; i < 65; i++) begin
            cyc(0, 1, full_words[i], 0, 0, 0);
            if (i == 62) chk("not_full_63", 32'(MemFull), 32'd0);
            if (i == 63) chk("full_64", 32'(MemFull), 32'd1);
        end
        chk("full_len", 32'(LoadCount), 32'd64);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'd252);
        run(1);
        chk("word63", IF_ID_Instr, full_words[63]);
        run(1);
        chk("beyond_63_valid", 32'(IF_ID_Valid), 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            logic rst, ld, st, br;
            logic [31:0] tgt;
            rst = $urandom_range(0, 39) == 0;
            ld  = $urandom_range(0, 7) == 0;
            st  = $urandom_range(0, 3) == 0;
            br  = $urandom_range(0, 7) == 0;
            tgt = $urandom_range(0, 7) == 0 ? $urandom : 32'($urandom_range(0, 300));
            cyc(rst, ld, $urandom, st, br, tgt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
